// File: rtl/rom_fetch_if.sv
// rom_fetch_if: program ROM read port plus the tagged byte stream toward the core
//   rom_addr/rom_data       : ROM address out, read data back one cycle later
//   byte_valid/data/addr    : FIFO head offered to the core
//   byte_ready              : core accepts the head byte
//   level                   : FIFO occupancy
interface rom_fetch_if #(parameter int DEPTH = 4);
  logic [14:0]            rom_addr;
  logic [7:0]             rom_data;
  logic                   byte_valid;
  logic [7:0]             byte_data;
  logic [14:0]            byte_addr;
  logic                   byte_ready;
  logic [$clog2(DEPTH):0] level;
  modport master(output rom_addr, byte_valid, byte_data, byte_addr, level, input rom_data, byte_ready);
  modport slave(input rom_addr, byte_valid, byte_data, byte_addr, level, output rom_data, byte_ready);
endinterface

// File: rtl/rom_fetch.sv
// rom_fetch: byte-stream prefetcher reading a 32Kx8 synchronous ROM into a tagged FIFO
//   clk         : single clock shared with ROM and core
//   sys_rst_n   : asynchronous active-low reset
//   fetch_en    : allows new ROM reads
//   redir_valid : one-cycle redirect strobe, flushes FIFO and in-flight byte
//   redir_addr  : new fetch address sampled with redir_valid
//   bus         : ROM port and byte stream (rom_fetch_if.master)
module rom_fetch #(
  parameter int          DEPTH      = 4,
  parameter logic [14:0] RESET_ADDR = 15'h0000
) (
  input  logic        clk,
  input  logic        sys_rst_n,
  input  logic        fetch_en,
  input  logic        redir_valid,
  input  logic [14:0] redir_addr,
  rom_fetch_if.master bus
);
  localparam int         AW   = $clog2(DEPTH);
  localparam logic [AW:0] FULL = (AW+1)'(DEPTH);
  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] RUN  = 1'b1;
  logic [0:0]    state;
  logic          pend;
  logic [14:0]   pend_addr;
  logic [14:0]   fetch_ptr;
  logic [7:0]    mem_data [DEPTH];
  logic [14:0]   mem_addr [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   level;
  logic          valid;
  logic          issue;
  logic          push;
  logic          pop;
  // credit counts the in-flight byte so the FIFO can never overflow; a same-cycle pop gives none
  assign issue = state == RUN && fetch_en && !redir_valid && (level + {{AW{1'b0}}, pend} < FULL);
  assign push  = pend && !redir_valid;
  assign valid = |level;
  assign pop   = valid && bus.byte_ready;
  always_ff @(posedge clk or negedge sys_rst_n)
    if (!sys_rst_n) begin
      state     <= IDLE;
      pend      <= 1'b0;
      pend_addr <= '0;
      fetch_ptr <= RESET_ADDR;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      level     <= '0;
    end else begin
      state <= fetch_en ? RUN : IDLE;
      pend  <= issue;
      if (issue) pend_addr <= fetch_ptr;
      if (redir_valid) begin
        fetch_ptr <= redir_addr;
        wr_ptr    <= '0;
        rd_ptr    <= '0;
        level     <= '0;
      end else begin
        if (issue) fetch_ptr <= fetch_ptr + 15'd1;
        if (push) wr_ptr <= wr_ptr + AW'(1);
        if (pop) rd_ptr <= rd_ptr + AW'(1);
        level <= level + {{AW{1'b0}}, push} - {{AW{1'b0}}, pop};
      end
    end
  always_ff @(posedge clk)
    if (push) begin
      mem_data[wr_ptr] <= bus.rom_data;
      mem_addr[wr_ptr] <= pend_addr;
    end
  assign bus.rom_addr   = fetch_ptr;
  assign bus.level      = level;
  assign bus.byte_valid = valid;
  assign bus.byte_data  = valid ? mem_data[rd_ptr] : '0;
  assign bus.byte_addr  = valid ? mem_addr[rd_ptr] : '0;
endmodule

// File: tb/tb_rom_fetch.sv
// tb_rom_fetch: directed vectors and corner-case sequences for rom_fetch (DEPTH=4)
module tb_rom_fetch;
  logic        clk = 1'b0;
  logic        sys_rst_n;
  logic        fetch_en;
  logic        redir_valid;
  logic [14:0] redir_addr;
  int          total = 0;
  int          bad = 0;
  rom_fetch_if #(.DEPTH(4)) bus();
  rom_fetch #(.DEPTH(4), .RESET_ADDR(15'h0000)) dut (
    .clk(clk), .sys_rst_n(sys_rst_n), .fetch_en(fetch_en),
    .redir_valid(redir_valid), .redir_addr(redir_addr), .bus(bus)
  );
  always #5 clk = ~clk;
  initial bus.rom_data = 8'h00;
  always @(posedge clk) bus.rom_data <= bus.rom_addr[7:0] ^ 8'h5A;
  typedef struct packed {
    logic        fe;
    logic        rdy;
    logic        rv;
    logic [14:0] rin;
    logic        ev;
    logic [7:0]  ed;
    logic [14:0] ea;
    logic [2:0]  el;
    logic [14:0] era;
  } vec_t;
  vec_t vec [17];
  function automatic vec_t mk(int fe, int rdy, int rv, int rin, int ev, int ed, int ea, int el, int era);
    vec_t m;
    m.fe = fe[0]; m.rdy = rdy[0]; m.rv = rv[0]; m.rin = rin[14:0];
    m.ev = ev[0]; m.ed = ed[7:0]; m.ea = ea[14:0]; m.el = el[2:0]; m.era = era[14:0];
    return m;
  endfunction
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask
  task automatic do_reset(input logic fe, input logic rdy);
    sys_rst_n = 1'b0; fetch_en = fe; bus.byte_ready = rdy; redir_valid = 1'b0; redir_addr = '0;
    step();
    step();
    sys_rst_n = 1'b1;
  endtask
  task automatic get_byte(output logic [14:0] a, output logic [7:0] d);
    int n = 0;
    while (!bus.byte_valid && n < 20) begin
      step();
      n++;
    end
    chk("byte_timeout", 32'(n < 20), 32'd1);
    a = bus.byte_addr;
    d = bus.byte_data;
    step();
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end
  initial begin
    logic [14:0] a;
    logic [7:0]  d;
    logic [14:0] wa [4];
    logic [7:0]  wd [4];
    wa[0] = 15'h7FFE; wa[1] = 15'h7FFF; wa[2] = 15'h0000; wa[3] = 15'h0001;
    wd[0] = 8'hA4;    wd[1] = 8'hA5;    wd[2] = 8'h5A;    wd[3] = 8'h5B;
    vec[0]  = mk(1, 1, 0, 'h0000, 0, 'h00, 'h0000, 0, 'h0000);
    vec[1]  = mk(1, 1, 0, 'h0000, 0, 'h00, 'h0000, 0, 'h0001);
    vec[2]  = mk(1, 1, 0, 'h0000, 1, 'h5A, 'h0000, 1, 'h0002);
    vec[3]  = mk(1, 1, 0, 'h0000, 1, 'h5B, 'h0001, 1, 'h0003);
    vec[4]  = mk(1, 1, 0, 'h0000, 1, 'h58, 'h0002, 1, 'h0004);
    vec[5]  = mk(1, 1, 0, 'h0000, 1, 'h59, 'h0003, 1, 'h0005);
    vec[6]  = mk(1, 1, 0, 'h0000, 1, 'h5E, 'h0004, 1, 'h0006);
    vec[7]  = mk(1, 1, 1, 'h1234, 0, 'h00, 'h0000, 0, 'h1234);
    vec[8]  = mk(1, 1, 0, 'h0000, 0, 'h00, 'h0000, 0, 'h1235);
    vec[9]  = mk(1, 1, 0, 'h0000, 1, 'h6E, 'h1234, 1, 'h1236);
    vec[10] = mk(1, 1, 0, 'h0000, 1, 'h6F, 'h1235, 1, 'h1237);
    vec[11] = mk(1, 0, 0, 'h0000, 1, 'h6F, 'h1235, 2, 'h1238);
    vec[12] = mk(1, 0, 0, 'h0000, 1, 'h6F, 'h1235, 3, 'h1239);
    vec[13] = mk(1, 0, 0, 'h0000, 1, 'h6F, 'h1235, 4, 'h1239);
    vec[14] = mk(1, 0, 0, 'h0000, 1, 'h6F, 'h1235, 4, 'h1239);
    vec[15] = mk(0, 1, 0, 'h0000, 1, 'h6C, 'h1236, 3, 'h1239);
    vec[16] = mk(0, 1, 0, 'h0000, 1, 'h6D, 'h1237, 2, 'h1239);
    sys_rst_n = 1'b0; fetch_en = 1'b0; bus.byte_ready = 1'b0; redir_valid = 1'b0; redir_addr = '0;
    #2;
    chk("rst_valid", 32'(bus.byte_valid), 32'd0);
    chk("rst_level", 32'(bus.level), 32'd0);
    chk("rst_rom_addr", 32'(bus.rom_addr), 32'd0);
    chk("rst_byte_data", 32'(bus.byte_data), 32'd0);
    do_reset(1'b1, 1'b1);
    for (int i = 0; i < 17; i++) begin
      fetch_en = vec[i].fe; bus.byte_ready = vec[i].rdy; redir_valid = vec[i].rv; redir_addr = vec[i].rin;
      step();
      chk($sformatf("v%0d_valid", i), 32'(bus.byte_valid), 32'(vec[i].ev));
      chk($sformatf("v%0d_data", i), 32'(bus.byte_data), 32'(vec[i].ed));
      chk($sformatf("v%0d_addr", i), 32'(bus.byte_addr), 32'(vec[i].ea));
      chk($sformatf("v%0d_level", i), 32'(bus.level), 32'(vec[i].el));
      chk($sformatf("v%0d_rom_addr", i), 32'(bus.rom_addr), 32'(vec[i].era));
    end
    redir_valid = 1'b0;
    do_reset(1'b1, 1'b0);
    repeat (10) step();
    chk("bp_level_full", 32'(bus.level), 32'd4);
    chk("bp_rom_addr", 32'(bus.rom_addr), 32'd4);
    repeat (3) step();
    chk("bp_rom_addr_hold", 32'(bus.rom_addr), 32'd4);
    bus.byte_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      get_byte(a, d);
      chk($sformatf("bp_addr%0d", i), 32'(a), 32'(i));
      chk($sformatf("bp_data%0d", i), 32'(d), 32'(i[7:0] ^ 8'h5A));
    end
    do_reset(1'b1, 1'b0);
    repeat (4) step();
    chk("rd_level_before", 32'(bus.level), 32'd2);
    redir_valid = 1'b1; redir_addr = 15'h1234;
    step();
    redir_valid = 1'b0;
    chk("rd_level_flushed", 32'(bus.level), 32'd0);
    bus.byte_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      get_byte(a, d);
      chk($sformatf("rd_addr%0d", i), 32'(a), 32'(15'h1234 + 15'(i)));
      chk($sformatf("rd_data%0d", i), 32'(d), 32'((8'h34 + 8'(i)) ^ 8'h5A));
    end
    redir_valid = 1'b1; redir_addr = 15'h7FFE;
    step();
    redir_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      get_byte(a, d);
      chk($sformatf("wrap_addr%0d", i), 32'(a), 32'(wa[i]));
      chk($sformatf("wrap_data%0d", i), 32'(d), 32'(wd[i]));
    end
    repeat (3) step();
    chk("sim_valid_pre", 32'(bus.byte_valid), 32'd1);
    chk("sim_level_pre", 32'(bus.level), 32'd1);
    redir_valid = 1'b1; redir_addr = 15'h0155;
    step();
    redir_valid = 1'b0;
    chk("sim_level_k1", 32'(bus.level), 32'd0);
    chk("sim_valid_k1", 32'(bus.byte_valid), 32'd0);
    step();
    chk("sim_valid_k2", 32'(bus.byte_valid), 32'd0);
    step();
    chk("sim_valid_k3", 32'(bus.byte_valid), 32'd1);
    chk("sim_addr_k3", 32'(bus.byte_addr), 32'h0155);
    chk("sim_data_k3", 32'(bus.byte_data), 32'h0F);
    do_reset(1'b1, 1'b0);
    repeat (5) step();
    chk("ar_level_before", 32'(bus.level), 32'd3);
    #2;
    sys_rst_n = 1'b0;
    #1;
    chk("ar_valid", 32'(bus.byte_valid), 32'd0);
    chk("ar_data", 32'(bus.byte_data), 32'd0);
    chk("ar_addr", 32'(bus.byte_addr), 32'd0);
    chk("ar_level", 32'(bus.level), 32'd0);
    chk("ar_rom_addr", 32'(bus.rom_addr), 32'd0);
    step();
    sys_rst_n = 1'b1; bus.byte_ready = 1'b1; fetch_en = 1'b1;
    step();
    chk("ar_c1_valid", 32'(bus.byte_valid), 32'd0);
    step();
    chk("ar_c2_valid", 32'(bus.byte_valid), 32'd0);
    step();
    chk("ar_c3_valid", 32'(bus.byte_valid), 32'd1);
    chk("ar_c3_addr", 32'(bus.byte_addr), 32'd0);
    chk("ar_c3_data", 32'(bus.byte_data), 32'h5A);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
